// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART blocks.
//   uart_state_e : receiver FSM state encoding
//   PARITY_EVEN / PARITY_ODD : parity-select values for the PARITY_ODD parameter
//   bit_width()  : number of bits needed to hold a value (counter sizing)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned PARITY_EVEN = 0;
    localparam int unsigned PARITY_ODD  = 1;

    // Width needed to represent max_val; never less than 1 bit.
    function automatic int unsigned bit_width(input int unsigned max_val);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((max_val >> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for a single asynchronous level input. Both flops reset
// to RST_VAL so an idle line does not look like activity coming out of reset.
//   clk_i  : destination clock
//   rst_i  : asynchronous reset, active low
//   d_i    : asynchronous input
//   q_o    : synchronised output (2 clk_i cycles of latency)
// -----------------------------------------------------------------------------
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments so each flop takes the pre-edge value of
    // its source; blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// Parametrised UART receiver with a valid/ready output holding register.
// Optional feature macro: UART_RX_PARITY_EN (adds one parity bit after the data
// bits and makes parity_err_o live; otherwise parity_err_o is tied to 0).
//   clk_i        : system clock
//   rst_i        : asynchronous reset, active low
//   RXD_i        : serial line, idle high, asynchronous to clk_i
//   data_o       : received word, LSB = first bit on the line
//   valid_o      : data_o and error flags valid
//   ready_i      : consumer accepts the word
//   frame_err_o  : first stop bit sampled low (qualified by valid_o)
//   parity_err_o : parity mismatch (qualified by valid_o)
//   overrun_o    : sticky, a frame completed while valid_o was high
//   busy_o       : receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = uart_pkg::PARITY_EVEN
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 RXD_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    import uart_pkg::*;

    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_frame: parameter out of range");
    end

    localparam int unsigned CNT_W = bit_width(CLKS_PER_BIT - 1);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    // ---------------------------------------------------------------- input sync
    logic rxd_s;

    uart_sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (RXD_i),
        .q_o   (rxd_s)
    );

    // ---------------------------------------------------------------- FSM state
    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 ferr_q, ferr_d;
    // Set when a frame ends with the line low (break); blocks re-arming until
    // the line has been seen high, so a held-low line yields exactly one word.
    logic                 wait_high_q, wait_high_d;

    logic                 sample;
    logic                 done;
    logic                 done_ferr;
    logic                 done_perr;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SEL = (PARITY_ODD != PARITY_EVEN);
    logic perr_q, perr_d;
`endif

    assign sample = (cnt_q == '0);

    // NOTE: every variable gets a default before the case statement, so no
    // path through this block can leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        stop_idx_d  = stop_idx_q;
        ferr_d      = ferr_q;
        wait_high_d = wait_high_q;
        done        = 1'b0;
        done_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d      = perr_q;
`endif

        // Bit timer free-runs while a frame is active and reloads a full bit
        // period on every sample point.
        if (state_q != ST_IDLE) begin
            cnt_d = sample ? CNT_FULL : cnt_q - CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (wait_high_q) begin
                    if (rxd_s) begin
                        wait_high_d = 1'b0;
                    end
                end else if (!rxd_s) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end

            ST_START: begin
                if (sample) begin
                    if (rxd_s) begin
                        state_d = ST_IDLE;      // glitch, not a start bit
                    end else begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
            end

            ST_DATA: begin
                if (sample) begin
                    shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        stop_idx_d = 1'b0;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample) begin
                    // Mismatch when received bit differs from XOR(data)^PAR_SEL.
                    perr_d     = (^shift_q) ^ PAR_SEL ^ rxd_s;
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif

            ST_STOP: begin
                if (sample) begin
                    if (!stop_idx_q) begin
                        ferr_d = !rxd_s;
                    end
                    if (stop_idx_q == LAST_STOP) begin
                        done        = 1'b1;
                        done_ferr   = stop_idx_q ? ferr_q : !rxd_s;
                        // Straight back to IDLE so a start edge in the
                        // remaining half bit is not missed.
                        state_d     = ST_IDLE;
                        wait_high_d = !rxd_s;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign done_perr = perr_q;
`else
    assign done_perr = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            stop_idx_q  <= 1'b0;
            ferr_q      <= 1'b0;
            wait_high_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            stop_idx_q  <= stop_idx_d;
            ferr_q      <= ferr_d;
            wait_high_q <= wait_high_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
`endif

    // ---------------------------------------------------------------- output register
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;

    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;

        if (valid_q && ready_i) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        // A completion in the same cycle as a handshake reloads the register,
        // so valid stays high across back-to-back words.
        if (done) begin
            if (!valid_q || ready_i) begin
                data_d       = shift_q;
                frame_err_d  = done_ferr;
                parity_err_d = done_perr;
                valid_d      = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign frame_err_o  = frame_err_q;
    assign parity_err_o = parity_err_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame
// Self-checking bench for uart_rx_frame (CLKS_PER_BIT=8, DATA_BITS=8,
// STOP_BITS=1, PARITY_ODD=0). Expected words go into a scoreboard queue when a
// frame is driven; a monitor pops and compares on every accepted handshake.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame;

    localparam int CPB = 8;
    localparam int DB  = 8;
    localparam int SB  = 1;
    localparam logic PAR_ODD = 1'b0;

`ifdef UART_RX_PARITY_EN
    localparam logic PERR_LIVE  = 1'b1;
    localparam int   FRAME_BITS = 1 + DB + 1 + SB;
`else
    localparam logic PERR_LIVE  = 1'b0;
    localparam int   FRAME_BITS = 1 + DB + SB;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rxd = 1'b1;
    logic          ready = 1'b1;
    logic [DB-1:0] data_o;
    logic          valid_o;
    logic          frame_err_o;
    logic          parity_err_o;
    logic          overrun_o;
    logic          busy_o;

    always #5 clk = ~clk;

    uart_rx_frame #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB),
        .STOP_BITS    (SB),
        .PARITY_ODD   (0)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .RXD_i        (rxd),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o),
        .overrun_o    (overrun_o),
        .busy_o       (busy_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    typedef struct packed {
        logic [DB-1:0] data;
        logic          ferr;
        logic          perr;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_exp(input logic [DB-1:0] d, input logic f, input logic p);
        exp_t e;
        e.data = d;
        e.ferr = f;
        e.perr = p & PERR_LIVE;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_o && ready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got data 0x%0h, expected no word", data_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("word_data", 32'(data_o), 32'(e.data));
                check("word_frame_err", 32'(frame_err_o), 32'(e.ferr));
                check("word_parity_err", 32'(parity_err_o), 32'(e.perr));
            end
        end
    end

    // ------------------------------------------------------------ line driver
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_data_bits(input logic [DB-1:0] d, input logic par_flip);
        for (int i = 0; i < DB; i++) begin
            rxd = d[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^d) ^ PAR_ODD ^ par_flip;
        tick(CPB);
`else
        if (par_flip) begin
            // no parity bit on the line in this build
        end
`endif
    endtask

    // Leaves the line at the stop value; callers return it to idle.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par_flip);
        rxd = 1'b0;
        tick(CPB);
        send_data_bits(d, par_flip);
        for (int i = 0; i < SB; i++) begin
            rxd = stop;
            tick(CPB);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int cycles;
        cycles = 0;
        while (sb_q.size() != 0 && cycles < budget) begin
            tick(1);
            cycles++;
        end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        logic [DB-1:0] data;
        logic          stop;
        logic          par_flip;
        logic          exp_ferr;
        logic          exp_perr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;

        vecs[0] = '{data: 8'h3E, stop: 1'b1, par_flip: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, par_flip: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, par_flip: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
        vecs[3] = '{data: 8'h81, stop: 1'b1, par_flip: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
        vecs[4] = '{data: 8'hA5, stop: 1'b0, par_flip: 1'b0, exp_ferr: 1'b1, exp_perr: 1'b0};
        vecs[5] = '{data: 8'h07, stop: 1'b1, par_flip: 1'b0, exp_ferr: 1'b0, exp_perr: 1'b0};
        vecs[6] = '{data: 8'h07, stop: 1'b1, par_flip: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b1};
        vecs[7] = '{data: 8'h5C, stop: 1'b1, par_flip: 1'b1, exp_ferr: 1'b0, exp_perr: 1'b1};

        // ---------------- reset state
        rst_n = 1'b0;
        rxd   = 1'b1;
        ready = 1'b1;
        tick(3);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_frame_err", 32'(frame_err_o), 32'd0);
        check("rst_parity_err", 32'(parity_err_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        rst_n = 1'b1;
        tick(2 * CPB);

        // ---------------- basic receive: busy latency and one-cycle valid
        push_exp(8'h3E, 1'b0, 1'b0);
        rxd = 1'b0;
        tick(2);
        check("busy_latency_2", 32'(busy_o), 32'd0);
        tick(1);
        check("busy_latency_3", 32'(busy_o), 32'd1);
        tick(CPB - 3);
        send_data_bits(8'h3E, 1'b0);
        rxd   = 1'b1;
        found = 0;
        for (int i = 0; i < 2 * CPB && found == 0; i++) begin
            tick(1);
            if (valid_o) found = 1;
        end
        check("basic_valid_seen", 32'(found), 32'd1);
        check("basic_data", 32'(data_o), 32'h3E);
        tick(1);
        check("basic_valid_pulse", 32'(valid_o), 32'd0);
        tick(CPB);
        wait_drain("basic_drain", 4 * CPB);

        // ---------------- table-driven frames
        foreach (vecs[i]) begin
            push_exp(vecs[i].data, vecs[i].exp_ferr, vecs[i].exp_perr);
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].par_flip);
            rxd = 1'b1;
            tick(2 * CPB);
        end
        wait_drain("table_drain", 4 * CPB);
        check("table_overrun", 32'(overrun_o), 32'd0);

        // ---------------- false start
        rxd = 1'b0;
        tick(3);
        check("false_start_busy", 32'(busy_o), 32'd1);
        rxd = 1'b1;
        tick(2 * CPB);
        check("false_start_idle", 32'(busy_o), 32'd0);
        check("false_start_no_valid", 32'(valid_o), 32'd0);

        // ---------------- framing error, line then held low
        push_exp(8'hA5, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0);
        tick(4 * CPB);
        check("ferr_hold_low_idle", 32'(busy_o), 32'd0);
        check("ferr_delivered", 32'(sb_q.size()), 32'd0);
        rxd = 1'b1;
        tick(2 * CPB);

        // ---------------- break from idle: exactly one 0x00 word with frame_err
        push_exp(8'h00, 1'b1, 1'b0);
        rxd = 1'b0;
        tick((FRAME_BITS + 6) * CPB);
        check("break_idle", 32'(busy_o), 32'd0);
        check("break_one_word", 32'(sb_q.size()), 32'd0);
        rxd = 1'b1;
        tick(2 * CPB);
        push_exp(8'h3C, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(2 * CPB);
        wait_drain("rearm_drain", 4 * CPB);

        // ---------------- overrun with ready low
        ready = 1'b0;
        push_exp(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(2 * CPB);
        send_frame(8'h22, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(2 * CPB);
        check("ovr_valid_held", 32'(valid_o), 32'd1);
        check("ovr_data_held", 32'(data_o), 32'h11);
        check("ovr_flag", 32'(overrun_o), 32'd1);
        ready = 1'b1;
        tick(1);
        check("ovr_cleared", 32'(overrun_o), 32'd0);
        check("ovr_valid_cleared", 32'(valid_o), 32'd0);
        check("ovr_drain", 32'(sb_q.size()), 32'd0);
        tick(CPB);

        // ---------------- reset during DATA bit 4
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            tick(CPB);
        end
        rxd = 1'b0;
        tick(CPB / 2);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_valid", 32'(valid_o), 32'd0);
        rxd = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3 * CPB);
        check("midrst_no_word", 32'(valid_o), 32'd0);
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(2 * CPB);
        wait_drain("midrst_drain", 4 * CPB);

        // ---------------- back-to-back frames at full rate
        push_exp(8'h01, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b0);
        push_exp(8'h80, 1'b0, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0);
        push_exp(8'hC3, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        push_exp(8'h6B, 1'b0, 1'b0);
        send_frame(8'h6B, 1'b1, 1'b0);
        rxd = 1'b1;
        tick(2 * CPB);
        wait_drain("b2b_drain", 4 * CPB);
        check("b2b_overrun", 32'(overrun_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver, successor to the fixed-format receiver on the RS-232 path. Deserialises `RXD_i` with configurable bit period, word length and stop-bit count, checks framing and optionally parity, and presents each word on a valid/ready output holding register. Sits between the board RXD pin and the command/byte consumer logic.

## Interface
- `CLKS_PER_BIT`, 8: clock cycles per bit. Range is ≥4.
- `DATA_BITS`, 8: word length. Range is 5–9.
- `STOP_BITS`, 1: stop bits expected, 1 or 2.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd. Used only with `UART_RX_PARITY_EN`.

- `clk_i` in 1: system clock. Single clock domain.
- `rst_i` in 1: reset, asynchronous, active-low.
- `RXD_i` in 1: serial line, idle high, asynchronous to `clk_i`.
- `data_o` out `DATA_BITS`: received word, LSB is the first bit received.
- `valid_o` out 1: `data_o` and the error flags are valid.
- `ready_i` in 1: consumer accepts the word.
- `frame_err_o` out 1: first stop bit sampled low. Qualified by `valid_o`.
- `parity_err_o` out 1: parity mismatch. Qualified by `valid_o`. Tied to 0 without the macro.
- `overrun_o` out 1: sticky. A frame completed while `valid_o` was high.
- `busy_o` out 1: FSM is not in IDLE.

## Operation
- `RXD_i` passes through a 2-flop synchroniser whose flops reset to 1. All logic uses the synchronised signal `rxd_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on `rxd_s`=0. The bit counter loads `CLKS_PER_BIT/2 - 1`.
  - START samples at mid-bit. If `rxd_s`=1, the start was false: go to IDLE and deliver nothing. If `rxd_s`=0, go to DATA, with the counter reloaded to `CLKS_PER_BIT-1`.
  - DATA takes `DATA_BITS` samples, one every `CLKS_PER_BIT` cycles. Bits shift in LSB first. Bit index width is `$clog2(DATA_BITS)`.
  - After DATA, go to PARITY if the macro is defined, otherwise to STOP. PARITY takes one sample. Expected parity is XOR(data) ^ `PARITY_ODD`.
  - STOP takes `STOP_BITS` samples. Only the first sample sets `frame_err`. The second stop sample is checked for timing only. After the last stop sample, go to IDLE immediately, so a start edge in the next half-bit is caught.
- Completion, evaluated in the cycle of the last stop sample:
  - If `valid_o`=0 or (`valid_o` & `ready_i`): load `data_o`, `frame_err_o` and `parity_err_o`, and set `valid_o`.
  - Otherwise keep the old word and flags, drop the new word, and set `overrun_o`.
- Handshake:
  - `valid_o` clears on the cycle after `valid_o & ready_i` unless a completion lands in the same cycle, in which case the new word is loaded and `valid_o` stays 1.
  - `data_o` and the flags are stable while `valid_o`=1 and `ready_i`=0.
- `overrun_o` clears on the next accepted handshake (`valid_o & ready_i`).
- A frame with `frame_err` is still delivered. A break condition (line held low) yields word 0x00 with `frame_err_o`=1. The FSM then waits in IDLE for `rxd_s`=1 before arming again, so exactly one word is produced per break.

## Timing
- Reset values:
  - `data_o` = 0, `valid_o` = 0, all error flags = 0, `busy_o` = 0.
  - FSM in IDLE; synchroniser flops = 1.
- Latency:
  - Falling edge on `RXD_i` to `busy_o`=1 is 3 cycles (2 synchroniser + 1 register).
  - Sample points fall at `CLKS_PER_BIT/2 + k·CLKS_PER_BIT` after start detection, for k = 0 (start), 1, 2, ….
  - `valid_o` rises 1 cycle after the last stop sample.
- Reset asserted mid-frame: everything returns to reset values asynchronously. The partial word is discarded and is not delivered after reset releases.
- Back-to-back frames at full rate, with `ready_i` held at 1: no words lost, `overrun_o` stays 0.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state exists, one parity bit is expected after the data bits, and `parity_err_o` is live.
- Undefined: no parity bit is expected, the PARITY state and XOR tree are absent, and `parity_err_o` = 0.

## Structure
- Package `uart_pkg`:
  - FSM state typedef.
  - Parity-select constants (`PARITY_EVEN`=0, `PARITY_ODD`=1).
  - Shared bit-width function for counter sizing.
- Sub-module `uart_sync2`: 2-flop synchroniser with a reset-value parameter. It is reused by the future transmitter's CTS input.

## Test plan
Parameters for all scenarios: `CLKS_PER_BIT`=8, `DATA_BITS`=8, `STOP_BITS`=1, `ready_i`=1 unless stated.
- Basic receive: frame 0x3E (bits 0,1,1,1,1,1,0,0 LSB first), stop bit 1 → `data_o`=0x3E, `valid_o` high for 1 cycle, no error flags.
- False start: `RXD_i` low for 3 cycles, then high → no `valid_o`, `busy_o` drops back to 0.
- Framing error: frame 0xA5 with stop bit 0 → `data_o`=0xA5, `frame_err_o`=1. Line held low afterwards → no second word until the line returns high.
- Overrun: `ready_i`=0, frames 0x11 then 0x22 → `data_o` stays 0x11 and `overrun_o`=1. Then raise `ready_i` → handshake completes and `overrun_o` clears.
- Parity, with the macro defined and `PARITY_ODD`=0: word 0x07 with parity bit 1 → `parity_err_o`=0. Same word with parity bit 0 → `parity_err_o`=1.
- Reset mid-frame: assert `rst_i`=0 during DATA bit 4, release, then send 0x5A → only 0x5A is delivered.
